ysyx_25020047_exu_mc: RTL and testbench
=======================================

Name: ysyx_25020047_exu_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle execute unit in the NPC core.
- Executes the RV32I ALU ops plus the RV32M subset MUL/MULHU/DIV/DIVU/REM/REMU.
- Uses a binary op code and valid/ready handshakes on both sides, so IDU→EXU→LSU/WBU can stall.
- ALU ops take 1 cycle. MUL/DIV ops iterate for XLEN cycles.

Parameters:
- XLEN, 32, datapath width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.
- TAG_W, 5, width of the pass-through rd tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight op, drop held result
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- in_op  in  4  op code (below)
- in_src1  in  XLEN  operand 1
- in_src2  in  XLEN  operand 2 (rdata2 or imm, muxed by IDU)
- in_rd  in  TAG_W  destination register tag
- in_wen  in  1  writeback-enable tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  XLEN  result
- out_rd  out  TAG_W  captured in_rd
- out_wen  out  1  captured in_wen
- busy  out  1  state is MUL or DIV

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU. All 16 codes are legal.
- States: IDLE, MUL, DIV, DONE. Internal down-counter cnt, width SHW+1.
- Accept: in_valid && in_ready && !flush.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back issue is therefore allowed while a result drains.
- Accept with ALU op (0–9):
  - Result is computed combinationally and registered into out_result.
  - Go to DONE. out_valid = 1 the cycle after accept.
- Accept with MUL/MULHU:
  - Latch operands, cnt = XLEN, go to MUL.
  - Shift-add one bit per cycle into a 2·XLEN unsigned product.
  - When cnt reaches 0, go to DONE with the low half (MUL) or high half (MULHU).
  - out_valid rises XLEN+1 cycles after accept.
- Accept with DIV/DIVU/REM/REMU:
  - Signed ops take absolute values; result sign is fixed up at the end.
    - Quotient sign = sign1 ^ sign2.
    - Remainder sign = sign1.
  - Restoring division, one bit per cycle, XLEN iterations, then DONE.
  - Latency is XLEN+1, same as MUL.
- Divide special cases bypass iteration and take the 1-cycle ALU path:
  - Divisor 0:
    - DIV/DIVU → all ones.
    - REM/REMU → src1.
  - Signed overflow (src1 = most negative, src2 = −1):
    - DIV → src1.
    - REM → 0.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use src2[SHW-1:0] only. SRA is arithmetic.
  - SLT/SLTU produce 1 or 0, zero-extended.
- DONE state:
  - out_valid = 1. out_result, out_rd and out_wen are held stable until out_ready.
  - On out_ready with no accept: go to IDLE, out_valid = 0 next cycle.
  - On out_ready with a simultaneous accept: load the new op.
- Tags: out_rd and out_wen are captured at accept, unchanged through iteration.
- Flush (sync):
  - Next state IDLE, out_valid = 0, cnt = 0.
  - No accept in the flush cycle, even with in_valid high.
  - Any partial MUL/DIV is discarded.
- Reset (sync, beats flush):
  - State IDLE, out_valid 0, out_result 0, out_rd 0, out_wen 0, busy 0, cnt 0.
  - Reset mid-iteration discards the op.
- busy = 1 in MUL/DIV only.
- in_ready = 0 during MUL/DIV.

Test Plan (XLEN=32):
- ADD 0xFFFFFFFF + 0x1, rd=5, out_ready=1 → out_valid next cycle, result 0x0, out_rd 5. SRA 0x80000000 by src2 = 0x24 (shamt 4) → 0xF8000000.
- MUL 0x12345678 × 0x9ABCDEF0 → low 0x242D2080 exactly 33 cycles after accept. MULHU same operands → 0x0B00EA4E. busy high 32 cycles, in_ready low throughout.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases on the 1-cycle path: DIVU x/0 → 0xFFFFFFFF. REM 0x1234/0 → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Raise out_ready with in_valid=1 (ADD 3+4) → first result consumed, 7 presented next cycle with no bubble.
- Flush at iteration cycle 10 of a DIV, with in_valid=1 in the same cycle → no accept, out_valid stays 0, state IDLE next cycle. rst asserted in DONE → all outputs 0 next cycle.

Source files
------------

// File: rtl/ysyx_25020047_exu_mc.sv
// Multi-cycle execute unit: single-cycle RV32I ALU ops plus iterative RV32M multiply/divide,
// with valid/ready handshakes on both the issue and the result side.
module ysyx_25020047_exu_mc #(
  parameter int XLEN  = 32,
  parameter int SHW   = $clog2(XLEN),
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             in_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_wen,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd14;
  localparam logic [3:0] OP_REMU = 4'd15;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);

  state_t               state_reg, state_next;
  logic [SHW:0]         cnt_reg, cnt_next;
  logic [2*XLEN-1:0]    acc_reg, acc_next;
  logic [XLEN-1:0]      opnd_reg, opnd_next;
  logic [1:0]           sel_reg, sel_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic [XLEN-1:0]      result_reg, result_next;
  logic [TAG_W-1:0]     rd_reg, rd_next;
  logic                 wen_reg, wen_next;

  logic                 accept;
  logic                 is_div_op, signed_div, is_rem_op, div_zero, div_ovf, take_alu;
  logic                 sign1, sign2;
  logic [SHW-1:0]       shamt;
  logic [XLEN-1:0]      alu_result;
  logic [XLEN:0]        mul_sum;
  logic [2*XLEN-1:0]    mul_prod;
  logic [XLEN:0]        div_shift;
  logic                 div_ge;
  logic [XLEN-1:0]      div_rem, div_quo;

  assign in_ready  = (state_reg == S_IDLE) || (state_reg == S_DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg == S_MUL) || (state_reg == S_DIV);
  assign out_result = result_reg;
  assign out_rd    = rd_reg;
  assign out_wen   = wen_reg;

  // Divide-by-zero and signed overflow short-circuit to the single-cycle path.
  assign is_div_op  = (in_op[3:2] == 2'b11);
  assign signed_div = (in_op == OP_DIV) || (in_op == OP_REM);
  assign is_rem_op  = (in_op == OP_REM) || (in_op == OP_REMU);
  assign div_zero   = (in_src2 == '0);
  assign div_ovf    = signed_div && (in_src1 == MIN_NEG) && (in_src2 == '1);
  assign take_alu   = (in_op < OP_MUL) || (is_div_op && (div_zero || div_ovf));
  assign sign1      = signed_div && in_src1[XLEN-1];
  assign sign2      = signed_div && in_src2[XLEN-1];
  assign shamt      = in_src2[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (in_op)
      OP_ADD:  alu_result = in_src1 + in_src2;
      OP_SUB:  alu_result = in_src1 - in_src2;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
      OP_XOR:  alu_result = in_src1 ^ in_src2;
      OP_OR:   alu_result = in_src1 | in_src2;
      OP_AND:  alu_result = in_src1 & in_src2;
      OP_SLL:  alu_result = in_src1 << shamt;
      OP_SRL:  alu_result = in_src1 >> shamt;
      OP_SRA:  alu_result = $signed(in_src1) >>> shamt;
      default: begin
        if (div_zero) alu_result = is_rem_op ? in_src1 : '1;
        else          alu_result = is_rem_op ? '0 : in_src1;
      end
    endcase
  end

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_prod  = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_reg}) : div_shift[XLEN-1:0];
    div_quo   = {acc_reg[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    sel_next    = sel_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;
    rd_next     = rd_reg;
    wen_next    = wen_reg;

    case (state_reg)
      S_MUL: begin
        acc_next = mul_prod;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next  = S_DONE;
          result_next = sel_reg[0] ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
        end
      end
      S_DIV: begin
        acc_next = {div_rem, div_quo};
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = S_DONE;
          if (sel_reg[1]) result_next = neg_r_reg ? -div_rem : div_rem;
          else            result_next = neg_q_reg ? -div_quo : div_quo;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      rd_next  = in_rd;
      wen_next = in_wen;
      sel_next = in_op[1:0];
      if (take_alu) begin
        result_next = alu_result;
        state_next  = S_DONE;
      end else if (!is_div_op) begin
        acc_next   = {{XLEN{1'b0}}, in_src1};
        opnd_next  = in_src2;
        cnt_next   = CNT_INIT;
        state_next = S_MUL;
      end else begin
        acc_next   = {{XLEN{1'b0}}, (sign1 ? -in_src1 : in_src1)};
        opnd_next  = sign2 ? -in_src2 : in_src2;
        neg_q_next = sign1 ^ sign2;
        neg_r_next = sign1;
        cnt_next   = CNT_INIT;
        state_next = S_DIV;
      end
    end

    if (flush) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      sel_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      rd_reg     <= '0;
      wen_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      sel_reg    <= sel_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
      rd_reg     <= rd_next;
      wen_reg    <= wen_next;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_exu_mc.sv
// Scoreboard bench for the multi-cycle execute unit: a driver pushes model results on accept,
// a negedge monitor pops and compares whenever a fresh result is presented.
`timescale 1ns/1ps
module tb_ysyx_25020047_exu_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_wen, busy, in_wen;
  logic [3:0]  in_op;
  logic [31:0] in_src1, in_src2, out_result;
  logic [4:0]  in_rd, out_rd;

  ysyx_25020047_exu_mc dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    int          cyc;
    logic [3:0]  op;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s bound expired actual=timeout expected=event", name);
  endtask

  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a | b;
      4'd6:  return a & b;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return sa >>> b[4:0];
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 4'd10) return 1;
    if (op >= 4'd12 && (b == 0 || ((op == 4'd12 || op == 4'd14) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen);
    exp_t e;
    int n = 0;
    in_valid = 1'b1;
    in_op = op; in_src1 = a; in_src2 = b; in_rd = rd; in_wen = wen;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail_now("issue_wait");
    end else begin
      e.res = ref_model(op, a, b);
      e.rd  = rd;
      e.wen = wen;
      e.cyc = cyc + lat_of(op, a, b);
      e.op  = op;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now(name);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a result is fresh when valid rises or follows a completed handshake.
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_rd;
  logic        held_wen;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid || prev_hs) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%08h expected=no_result", out_result);
          end else begin
            e = sb_q.pop_front();
            chk("result", out_result, e.res);
            chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
            chk("out_wen", {31'b0, out_wen}, {31'b0, e.wen});
            chk("latency_cycle", cyc, e.cyc);
            $display("txn op=%0d rd=%0d wen=%0d result=0x%08h cyc=%0d", e.op, out_rd, out_wen, out_result, cyc);
          end
          held_res = out_result;
          held_rd  = out_rd;
          held_wen = out_wen;
        end else begin
          chk("hold_result", out_result, held_res);
          chk("hold_rd", {27'b0, out_rd}, {27'b0, held_rd});
          chk("hold_wen", {31'b0, out_wen}, {31'b0, held_wen});
        end
        prev_hs = out_ready;
      end
      prev_valid = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nbusy, nbad;
    logic [31:0] r0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_rd = '0; in_wen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_out_wen", {31'b0, out_wen}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1);
    issue(4'd9, 32'h8000_0000, 32'h24, 5'd6, 1'b1);
    @(posedge clk); #1;

    // MUL: busy for XLEN cycles with in_ready low throughout.
    issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 1'b1);
    n = 0; nbusy = 0; nbad = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) nbusy++;
      if (busy === 1'b1 && in_ready !== 1'b0) nbad++;
    end
    chk("mul_busy_cycles", nbusy, 32'd32);
    chk("mul_in_ready_low", nbad, 32'd0);
    @(posedge clk); #1;
    issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 1'b0);
    issue(4'd12, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
    issue(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    issue(4'd13, 32'd100, 32'd7, 5'd11, 1'b1);
    issue(4'd15, 32'd100, 32'd7, 5'd12, 1'b1);
    issue(4'd13, 32'hDEAD_BEEF, 32'd0, 5'd13, 1'b1);
    issue(4'd14, 32'h1234, 32'd0, 5'd14, 1'b1);
    issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);
    @(posedge clk); #1;

    // Backpressure then a zero-bubble handoff.
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd2, 5'd3, 1'b1);
    wait_valid("bp_valid");
    r0 = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", out_result, r0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd0, 32'd3, 32'd4, 5'd4, 1'b1);
    chk("no_bubble_valid", {31'b0, out_valid}, 32'd1);
    chk("no_bubble_result", out_result, 32'd7);
    @(posedge clk); #1;

    // Flush at DIV iteration cycle 10 with in_valid high.
    issue(4'd12, 32'd1000, 32'd3, 5'd20, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    void'(sb_q.pop_back());
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_src1 = 32'd1; in_src2 = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_quiet", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Flush in IDLE with in_valid high must not accept.
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", {31'b0, out_valid}, 32'd0);

    // Flush while holding a result drops it.
    out_ready = 1'b0;
    issue(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd21, 1'b1);
    wait_valid("flush_done_valid");
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_drop", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized phase with random consumer backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 250; t++) begin
      issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
    @(posedge clk); #1;

    // Reset while holding a result.
    out_ready = 1'b0;
    issue(4'd0, 32'd5, 32'd6, 5'd9, 1'b1);
    wait_valid("rst_done_valid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_done_valid_0", {31'b0, out_valid}, 32'd0);
    chk("rst_done_result_0", out_result, 32'd0);
    chk("rst_done_rd_0", {27'b0, out_rd}, 32'd0);
    chk("rst_done_wen_0", {31'b0, out_wen}, 32'd0);
    chk("rst_done_busy_0", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
